// File: rtl/gpu_command_engine.sv
// Byte-stream command engine: parses UART command packets and streams
// clipped pixel writes to the framebuffer at one pixel per clock.
module gpu_command_engine #(
   parameter int unsigned BITS_PER_PIXEL = 12,
   parameter int unsigned RESOLUTION_W   = 640,
   parameter int unsigned RESOLUTION_H   = 480,
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic                      i_Clock,
   input  logic                      i_Reset,
   input  logic                      i_Rx_DV,
   input  logic [7:0]                i_Rx_Byte,
   output logic                      o_Write_Enable,
   output logic [31:0]               o_Write_Addr,
   output logic [BITS_PER_PIXEL-1:0] o_Write_Data,
   output logic                      o_Busy,
   output logic                      o_Done,
   output logic                      o_Error
);

   localparam int unsigned TW  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [16:0] W17 = 17'(RESOLUTION_W);
   localparam logic [16:0] H17 = 17'(RESOLUTION_H);
   localparam logic [31:0] W32 = 32'(RESOLUTION_W);

   localparam logic [7:0] OP_SET   = 8'h01;
   localparam logic [7:0] OP_FILL  = 8'h02;
   localparam logic [7:0] OP_CLEAR = 8'h03;

   typedef enum logic [2:0] {S_IDLE, S_RECV, S_CLIP, S_EXEC, S_DONE} state_e;

   state_e                    state_q, state_d;
   logic [7:0]                op_q, op_d;
   logic [3:0]                cnt_q, cnt_d;
   logic [TW-1:0]             timer_q, timer_d;
   logic [79:0]               pay_q, pay_d;
   logic [16:0]               x_q, x_d, y_q, y_d, xs_q, xs_d, xe_q, xe_d, ye_q, ye_d;
   logic [31:0]               row_q, row_d, pix_q, pix_d;
   logic [BITS_PER_PIXEL-1:0] col_q, col_d;
   logic                      we_q, we_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic [31:0]               addr_q, addr_d;
   logic [BITS_PER_PIXEL-1:0] data_q, data_d;

   logic [15:0] cx0, cy0, cw, ch;
   logic [16:0] x_sum, y_sum, x_lim, y_lim, x_inc, y_inc;
   logic [3:0]  last_idx;
   logic        clip_empty;
   logic [31:0] row_c;

   // Decode packet fields and the clipped rectangle from the payload buffer
   always_comb begin
      cx0      = 16'd0;
      cy0      = 16'd0;
      cw       = 16'(RESOLUTION_W);
      ch       = 16'(RESOLUTION_H);
      last_idx = 4'd1;
      case (op_q)
         OP_SET: begin
            cx0      = pay_q[47:32];
            cy0      = pay_q[63:48];
            cw       = 16'd1;
            ch       = 16'd1;
            last_idx = 4'd5;
         end
         OP_FILL: begin
            cx0      = pay_q[15:0];
            cy0      = pay_q[31:16];
            cw       = pay_q[47:32];
            ch       = pay_q[63:48];
            last_idx = 4'd9;
         end
         default: ;
      endcase
      x_sum      = {1'b0, cx0} + {1'b0, cw};
      y_sum      = {1'b0, cy0} + {1'b0, ch};
      x_lim      = (x_sum > W17) ? W17 : x_sum;
      y_lim      = (y_sum > H17) ? H17 : y_sum;
      clip_empty = (cw == 16'd0) || (ch == 16'd0) ||
                   ({1'b0, cx0} >= W17) || ({1'b0, cy0} >= H17);
      row_c      = 32'(cy0) * W32;
      x_inc      = x_q + 17'd1;
      y_inc      = y_q + 17'd1;
   end

   // Next-state and output logic
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      timer_d = timer_q;
      pay_d   = pay_q;
      x_d     = x_q;
      y_d     = y_q;
      xs_d    = xs_q;
      xe_d    = xe_q;
      ye_d    = ye_q;
      row_d   = row_q;
      pix_d   = pix_q;
      col_d   = col_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (i_Rx_DV) begin
               if (i_Rx_Byte == OP_SET || i_Rx_Byte == OP_FILL || i_Rx_Byte == OP_CLEAR) begin
                  op_d    = i_Rx_Byte;
                  cnt_d   = 4'd0;
                  timer_d = '0;
                  state_d = S_RECV;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_RECV: begin
            if (i_Rx_DV) begin
               pay_d   = {i_Rx_Byte, pay_q[79:8]};
               cnt_d   = cnt_q + 4'd1;
               timer_d = '0;
               if (cnt_q == last_idx) state_d = S_CLIP;
            end else if (timer_q == TW'(TIMEOUT_CYCLES)) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         S_CLIP: begin
            err_d   = i_Rx_DV;
            x_d     = {1'b0, cx0};
            xs_d    = {1'b0, cx0};
            y_d     = {1'b0, cy0};
            xe_d    = x_lim;
            ye_d    = y_lim;
            row_d   = row_c;
            pix_d   = row_c + 32'(cx0);
            col_d   = pay_q[64 +: BITS_PER_PIXEL];
            state_d = clip_empty ? S_DONE : S_EXEC;
         end
         S_EXEC: begin
            err_d  = i_Rx_DV;
            we_d   = 1'b1;
            addr_d = pix_q;
            data_d = col_q;
            if (x_inc == xe_q) begin
               if (y_inc == ye_q) begin
                  state_d = S_DONE;
               end else begin
                  y_d   = y_inc;
                  x_d   = xs_q;
                  row_d = row_q + W32;
                  pix_d = row_q + W32 + 32'(xs_q);
               end
            end else begin
               x_d   = x_inc;
               pix_d = pix_q + 32'd1;
            end
         end
         S_DONE: begin
            err_d   = i_Rx_DV;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State and registered outputs
   always_ff @(posedge i_Clock or negedge i_Reset) begin
      if (!i_Reset) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         cnt_q   <= '0;
         timer_q <= '0;
         pay_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         xs_q    <= '0;
         xe_q    <= '0;
         ye_q    <= '0;
         row_q   <= '0;
         pix_q   <= '0;
         col_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         timer_q <= timer_d;
         pay_q   <= pay_d;
         x_q     <= x_d;
         y_q     <= y_d;
         xs_q    <= xs_d;
         xe_q    <= xe_d;
         ye_q    <= ye_d;
         row_q   <= row_d;
         pix_q   <= pix_d;
         col_q   <= col_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign o_Write_Enable = we_q;
   assign o_Write_Addr   = addr_q;
   assign o_Write_Data   = data_q;
   assign o_Busy         = busy_q;
   assign o_Done         = done_q;
   assign o_Error        = err_q;

endmodule

// File: doc/gpu_command_engine.md
# gpu_command_engine

Byte-stream command engine for the GPU: consumes received UART bytes (`i_Rx_DV`/`i_Rx_Byte`), parses fixed-length command packets and drives the framebuffer write port. It supports single-pixel writes, clipped rectangle fills and full-screen clears at one pixel per clock. It sits between `uart_receiver` and the framebuffer write port and is parametrised in resolution and pixel width.

## Interface
- `BITS_PER_PIXEL`, 12: colour width, 1..16.
- `RESOLUTION_W`, 640: framebuffer width in pixels, ≤ 65535.
- `RESOLUTION_H`, 480: framebuffer height in pixels, ≤ 65535.
- `TIMEOUT_CYCLES`, 100000: maximum idle gap between bytes of one packet.
- `i_Clock` in 1: sole clock.
- `i_Reset` in 1: reset, asynchronous, active-low.
- `i_Rx_DV` in 1: one-cycle byte-valid strobe.
- `i_Rx_Byte` in 8: received byte, valid with `i_Rx_DV`.
- `o_Write_Enable` out 1: framebuffer write strobe.
- `o_Write_Addr` out 32: linear address `y*RESOLUTION_W + x`, zero-extended.
- `o_Write_Data` out `BITS_PER_PIXEL`: pixel colour.
- `o_Busy` out 1: high from the first byte of a packet until the last write retires.
- `o_Done` out 1: one-cycle pulse after a command completes, including commands with zero writes.
- `o_Error` out 1: one-cycle pulse on bad opcode, timeout or overrun.

## Operation
- Packet format: opcode byte, then payload. All 16-bit fields are little-endian. Colour is 2 bytes; the low `BITS_PER_PIXEL` bits are used and the rest ignored.
  - 0x01 SET_PIXEL: x, y, colour (6 payload bytes).
  - 0x02 FILL_RECT: x0, y0, w, h, colour (10 payload bytes).
  - 0x03 CLEAR: colour (2 payload bytes). Equivalent to FILL_RECT 0, 0, W, H.
- States:
  - IDLE: on a byte, if the opcode is valid → RECV; otherwise pulse `o_Error` and stay in IDLE.
  - RECV: shift payload bytes in. On the last byte → CLIP. If the gap counter reaches `TIMEOUT_CYCLES` → IDLE with an `o_Error` pulse.
  - CLIP: compute the clipped rectangle (1 cycle), then → EXEC, or → DONE if the rectangle is empty.
  - EXEC: issue one write per cycle, scanning x-inner, y-outer. After the last write → DONE.
  - DONE: pulse `o_Done` (1 cycle) → IDLE.
- Clip rules:
  - `x_end = min(x0+w, W)` and `y_end = min(y0+h, H)`, computed in 17 bits so there is no wrap.
  - The rectangle is empty if `w==0`, `h==0`, `x0>=W` or `y0>=H`.
  - SET_PIXEL is treated as w=h=1.
- Address: maintain a row base and add 1 per pixel. No multiplier in the scan loop; the row base advances by W per row.
- A byte arriving in CLIP, EXEC or DONE is dropped and pulses `o_Error`. State is unaffected.
- Reset (async, active-low) forces IDLE. All outputs clear to 0: `o_Write_Enable`, `o_Write_Addr`, `o_Write_Data`, `o_Busy`, `o_Done`, `o_Error`. A write in progress stops at once, and no partial command resumes after release.

## Timing
- Let E be the edge that samples the final payload byte. CLIP occupies the cycle after E.
- The first write is registered at edge E+2. Write k (0-based) is valid in the cycle after edge E+2+k.
- The N clipped writes are contiguous, with no bubbles between rows.
- `o_Done` goes high after edge E+2+N for one cycle (E+2 if N=0).
- `o_Busy` rises after the edge sampling the opcode and falls with the `o_Done` cycle, i.e. it is low during the `o_Done` pulse.
- Throughput: back-to-back packets are accepted from the cycle `o_Done` is high. A byte arriving in the DONE cycle is treated as an overrun.
- Timeout counter: reset on every accepted byte. Abort happens when it equals `TIMEOUT_CYCLES`.
- `o_Error` pulses are registered and last one cycle. Simultaneous causes produce a single pulse.

## Test plan
- SET_PIXEL x=3, y=2, colour 0x0ABC → exactly one write: addr 1283, data 0xABC, at E+2; `o_Done` after E+3.
- FILL_RECT x0=638, y0=478, w=4, h=3 → 4 writes to addr 306558, 306559, 307198, 307199 in consecutive cycles; no out-of-range address is produced.
- CLEAR 0x0F00 → 307200 consecutive writes, addr 0..307199, data 0xF00. A byte injected mid-fill gives an `o_Error` pulse with the fill uninterrupted.
- Opcode 0x7F → `o_Error` pulse, no write, `o_Busy` stays low. A following SET_PIXEL executes correctly.
- Bytes 0x01, 0x05, then silence for `TIMEOUT_CYCLES` → `o_Error` pulse, return to IDLE. A new SET_PIXEL x=0, y=0 writes addr 0.
- Reset asserted during the 10th write of a FILL_RECT → `o_Write_Enable` low immediately and all outputs 0. After release, no further writes occur until a new packet arrives.
